// File: rtl/button_debounce.sv
// Multi-channel pushbutton debouncer: 2-flop synchronizer, per-channel stability counter, registered level.
// Define BUTTON_DEBOUNCE_RISE_PULSE_EN to build the o_rise pulse logic; otherwise o_rise is tied to 0.
module button_debounce #(
    parameter int N_BUTTON        = 1,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [N_BUTTON-1:0] i_signal,
    output logic [N_BUTTON-1:0] o_signal,
    output logic [N_BUTTON-1:0] o_rise
);

    localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic [N_BUTTON-1:0]  sync0_q;
    logic [N_BUTTON-1:0]  sync1_q;
    logic [N_BUTTON-1:0]  level_q;
    logic [N_BUTTON-1:0]  level_d;
    logic [CNT_WIDTH-1:0] cnt_q [N_BUTTON];
    logic [CNT_WIDTH-1:0] cnt_d [N_BUTTON];

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement (including a glitch back) restarts it.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < N_BUTTON; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            sync0_q <= '0;
            sync1_q <= '0;
            level_q <= '0;
            for (int i = 0; i < N_BUTTON; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0_q <= i_signal;
            sync1_q <= sync0_q;
            level_q <= level_d;
            for (int i = 0; i < N_BUTTON; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign o_signal = level_q;

`ifdef BUTTON_DEBOUNCE_RISE_PULSE_EN
    logic [N_BUTTON-1:0] rise_q;
    logic [N_BUTTON-1:0] rise_d;

    // Pulse is registered alongside the level, so it is high in the cycle the new 1 first appears.
    always_comb begin
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rise_q <= '0;
        end else begin
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;
`else
    assign o_rise = '0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce (2 channels, 4-sample debounce)
// against a sample-window reference model.
module tb_button_debounce;

    localparam int NB = 2;
    localparam int DC = 4;
`ifdef BUTTON_DEBOUNCE_RISE_PULSE_EN
    localparam bit RISE_EN = 1'b1;
`else
    localparam bit RISE_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] sig;
    logic [NB-1:0] o_sig;
    logic [NB-1:0] o_rise;

    always #5 clk = ~clk;

    button_debounce #(
        .N_BUTTON        (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .i_clock  (clk),
        .i_reset  (rst_n),
        .i_signal (sig),
        .o_signal (o_sig),
        .o_rise   (o_rise)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: raw input value sampled at every clock edge since reset
    // (zero-padded), plus the currently accepted level per channel.
    logic [NB-1:0] hist [$];
    logic [NB-1:0] m_out;
    logic [NB-1:0] m_rise;

    task automatic chk(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        for (int j = 0; j < DC + 2; j++) hist.push_back('0);
        m_out  = '0;
        m_rise = '0;
    endtask

    // A channel flips when the raw samples taken 2..DC+1 edges ago (the
    // synchronizer delay) all differ from the accepted level.
    task automatic model_edge();
        hist.push_back(sig);
        if (hist.size() > 64) void'(hist.pop_front());
        m_rise = '0;
        for (int ch = 0; ch < NB; ch++) begin
            bit all_differ;
            all_differ = 1'b1;
            for (int j = 0; j < DC; j++) begin
                if (hist[hist.size() - 3 - j][ch] == m_out[ch]) all_differ = 1'b0;
            end
            if (all_differ) begin
                m_out[ch]  = ~m_out[ch];
                m_rise[ch] = m_out[ch];
            end
        end
    endtask

    function automatic logic [NB-1:0] exp_rise();
        return RISE_EN ? m_rise : '0;
    endfunction

    // Called 1 time unit after an edge: drive, clock, then sample 1 unit later.
    task automatic step(input logic [NB-1:0] v, input string tag);
        sig = v;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        chk({tag, "_sig"}, o_sig, m_out);
        chk({tag, "_rise"}, o_rise, exp_rise());
    endtask

    task automatic reset_now(input string tag);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk({tag, "_async_sig"}, o_sig, '0);
        chk({tag, "_async_rise"}, o_rise, '0);
        #1;
    endtask

    initial begin
        logic [NB-1:0] cur;
        rst_n = 1'b0;
        sig   = 2'b11;
        model_clear();
        #1;
        chk("por_sig", o_sig, 2'b00);
        chk("por_rise", o_rise, 2'b00);

        // Reset held with inputs high, then release: accepted on 6th post-release edge.
        for (int i = 0; i < 4; i++) step(2'b11, "rst_hold");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(2'b11, "rel_wait");
        chk("rel_before_sig", o_sig, 2'b00);
        step(2'b11, "rel_accept");
        chk("rel_accept_const_sig", o_sig, 2'b11);
        chk("rel_accept_const_rise", o_rise, RISE_EN ? 2'b11 : 2'b00);
        step(2'b11, "rel_after");
        chk("rel_after_const_rise", o_rise, 2'b00);

        // Back to zero on both, then a clean step on channel 0 only.
        for (int i = 0; i < 8; i++) step(2'b00, "fall");
        chk("fall_const_sig", o_sig, 2'b00);
        for (int i = 0; i < 5; i++) step(2'b01, "clean0_wait");
        chk("clean0_before_sig", o_sig, 2'b00);
        step(2'b01, "clean0_accept");
        chk("clean0_const_sig", o_sig, 2'b01);
        chk("clean0_const_rise", o_rise, RISE_EN ? 2'b01 : 2'b00);
        step(2'b01, "clean0_after");
        chk("clean0_after_const_rise", o_rise, 2'b00);

        // Bouncing rise on channel 0 from a low level.
        for (int i = 0; i < 8; i++) step(2'b00, "bounce_pre");
        step(2'b01, "bounce"); step(2'b00, "bounce"); step(2'b01, "bounce");
        step(2'b01, "bounce"); step(2'b00, "bounce"); step(2'b01, "bounce");
        for (int i = 0; i < 8; i++) step(2'b01, "bounce_hold");
        chk("bounce_const_sig", o_sig, 2'b01);

        // Channel 1 high and settled, then a 3-cycle low glitch must be ignored.
        for (int i = 0; i < 8; i++) step(2'b11, "ch1_up");
        chk("ch1_up_const_sig", o_sig, 2'b11);
        for (int i = 0; i < 3; i++) step(2'b01, "ch1_glitch");
        for (int i = 0; i < 8; i++) step(2'b11, "ch1_recover");
        chk("ch1_glitch_const_sig", o_sig, 2'b11);

        // Reset in the middle of a count on channel 0, then a fresh full count.
        for (int i = 0; i < 8; i++) step(2'b00, "mid_pre");
        for (int i = 0; i < 4; i++) step(2'b01, "mid_count");
        reset_now("mid");
        step(2'b01, "mid_in_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(2'b01, "mid_recount");
        chk("mid_recount_const_sig", o_sig, 2'b00);
        step(2'b01, "mid_accept");
        chk("mid_accept_const_sig", o_sig, 2'b01);

        // Random bouncing on both channels with occasional resets.
        cur = 2'b01;
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
            end
            if ($urandom_range(0, 199) == 0) begin
                reset_now("rnd");
                step(cur, "rnd_in_reset");
                rst_n = 1'b1;
            end
            step(cur, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
